// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
// Holds the controller state encoding, the default mult/div latency and the register-zero constant.
package hazard_stall_unit_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } hz_state_e;

   localparam int unsigned MULDIV_CYCLES_DEF = 4;
   localparam logic [4:0]  REG_ZERO          = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// EX-stage hazard fields in, stage write/flush controls out.
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface hazard_stall_unit_if #(
   parameter int unsigned STALL_CNT_W = 16
);
   logic [4:0]             ID_Rs;
   logic [4:0]             ID_Rt;
   logic                   ID_UsesRt;
   logic                   EX_MemRead;
   logic [4:0]             EX_DestReg;
   logic                   EX_IsMulDiv;
   logic                   EX_BranchTaken;
   logic                   Stall_Clr;
   logic                   PC_Write;
   logic                   IFID_Write;
   logic                   IFID_Flush;
   logic                   IDEX_Write;
   logic                   IDEX_Flush;
   logic                   EXMEM_Bubble;
   logic                   MulDiv_Busy;
   logic [STALL_CNT_W-1:0] Stall_Cycles;

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_DestReg,
             EX_IsMulDiv, EX_BranchTaken, Stall_Clr,
      input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
             EXMEM_Bubble, MulDiv_Busy, Stall_Cycles
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_DestReg,
             EX_IsMulDiv, EX_BranchTaken, Stall_Clr,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
             EXMEM_Bubble, MulDiv_Busy, Stall_Cycles
   );
endinterface

// File: rtl/sat_counter.sv
// Parameterized-width up counter that saturates at all-ones.
// A synchronous clear takes priority over the increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and mult/div EX occupancy.
// Also keeps a saturating count of cycles in which the PC was held.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEF,
   parameter int unsigned STALL_CNT_W   = 16
) (
   input logic                Clk,
   input logic                Rst_n,
   hazard_stall_unit_if.slave hz
);

   localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

   hz_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_bub;
   logic       load_use;

   assign load_use = hz.EX_MemRead && (hz.EX_DestReg != REG_ZERO) &&
                     ((hz.EX_DestReg == hz.ID_Rs) ||
                      (hz.ID_UsesRt && (hz.EX_DestReg == hz.ID_Rt)));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_we     = 1'b1;
      ifid_we   = 1'b1;
      idex_we   = 1'b1;
      ifid_fl   = 1'b0;
      idex_fl   = 1'b0;
      exmem_bub = 1'b0;
      unique case (state_q)
         RUN: begin
            if (hz.EX_IsMulDiv) begin
               pc_we     = 1'b0;
               ifid_we   = 1'b0;
               idex_we   = 1'b0;
               exmem_bub = 1'b1;
               cnt_d     = CNT_LOAD;
               state_d   = WAIT;
            end else if (hz.EX_BranchTaken) begin
               ifid_fl = 1'b1;
               idex_fl = 1'b1;
            end else if (load_use) begin
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               idex_fl = 1'b1;
            end
         end
         WAIT: begin
            // EX still holds the mult/div, so branch and load-use inputs are irrelevant here
            if (cnt_q != 4'd1) begin
               pc_we     = 1'b0;
               ifid_we   = 1'b0;
               idex_we   = 1'b0;
               exmem_bub = 1'b1;
               cnt_d     = cnt_q - 4'd1;
            end else begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      if (!Rst_n) begin
         pc_we     = 1'b0;
         ifid_we   = 1'b0;
         idex_we   = 1'b0;
         ifid_fl   = 1'b1;
         idex_fl   = 1'b1;
         exmem_bub = 1'b1;
      end
   end

   assign hz.PC_Write     = pc_we;
   assign hz.IFID_Write   = ifid_we;
   assign hz.IFID_Flush   = ifid_fl;
   assign hz.IDEX_Write   = idex_we;
   assign hz.IDEX_Flush   = idex_fl;
   assign hz.EXMEM_Bubble = exmem_bub;
   assign hz.MulDiv_Busy  = (state_q == WAIT) && Rst_n;

   sat_counter #(
      .W(STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (Clk),
      .rst_n (Rst_n),
      .clr   (hz.Stall_Clr),
      .inc   (!pc_we),
      .count (hz.Stall_Cycles)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed vectors push expected outputs,
// a monitor pops one entry per cycle and compares mid-cycle.
module tb_hazard_stall_unit;

   localparam logic [5:0] DEF = 6'b110100;
   localparam logic [5:0] FRZ = 6'b000001;
   localparam logic [5:0] BRN = 6'b111110;
   localparam logic [5:0] LDU = 6'b000110;
   localparam logic [5:0] RST = 6'b001011;

   typedef struct {
      string      name;
      logic [5:0] ctrl;
      logic       busy;
      logic [3:0] sc;
   } exp_t;

   logic Clk;
   logic Rst_n;
   exp_t sb[$];
   int   checks;
   int   errors;

   hazard_stall_unit_if #(.STALL_CNT_W(4)) hz_if ();

   hazard_stall_unit #(
      .MULDIV_CYCLES(4),
      .STALL_CNT_W  (4)
   ) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .hz    (hz_if)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic step(input string nm, input logic rstn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic mr, input logic [4:0] dest, input logic md,
                       input logic br, input logic clr,
                       input logic [5:0] ctrl, input logic busy, input logic [3:0] sc);
      exp_t e;
      @(negedge Clk);
      Rst_n                = rstn;
      hz_if.ID_Rs          = rs;
      hz_if.ID_Rt          = rt;
      hz_if.ID_UsesRt      = ur;
      hz_if.EX_MemRead     = mr;
      hz_if.EX_DestReg     = dest;
      hz_if.EX_IsMulDiv    = md;
      hz_if.EX_BranchTaken = br;
      hz_if.Stall_Clr      = clr;
      e.name = nm;
      e.ctrl = ctrl;
      e.busy = busy;
      e.sc   = sc;
      sb.push_back(e);
   endtask

   // Monitor: compare the outputs presented during each cycle, before the next rising edge
   initial begin
      exp_t       e;
      logic [5:0] act;
      forever begin
         @(negedge Clk);
         #3;
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {hz_if.PC_Write, hz_if.IFID_Write, hz_if.IFID_Flush,
                   hz_if.IDEX_Write, hz_if.IDEX_Flush, hz_if.EXMEM_Bubble};
            checks++;
            if (act !== e.ctrl) begin
               errors++;
               $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
            end
            checks++;
            if (hz_if.MulDiv_Busy !== e.busy) begin
               errors++;
               $display("FAIL %s busy: got %b expected %b", e.name, hz_if.MulDiv_Busy, e.busy);
            end
            checks++;
            if (hz_if.Stall_Cycles !== e.sc) begin
               errors++;
               $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, hz_if.Stall_Cycles, e.sc);
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      Rst_n                = 1'b0;
      hz_if.ID_Rs          = '0;
      hz_if.ID_Rt          = '0;
      hz_if.ID_UsesRt      = 1'b0;
      hz_if.EX_MemRead     = 1'b0;
      hz_if.EX_DestReg     = '0;
      hz_if.EX_IsMulDiv    = 1'b0;
      hz_if.EX_BranchTaken = 1'b0;
      hz_if.Stall_Clr      = 1'b0;

      //    name          rstn rs rt ur mr dst md br clr  ctrl busy sc
      step("reset0",        0,  0, 0, 0, 0, 0, 0, 0, 0,  RST, 0,  0);
      step("reset1",        0,  0, 0, 0, 0, 0, 0, 0, 0,  RST, 0,  0);
      step("idle",          1,  0, 0, 0, 0, 0, 0, 0, 0,  DEF, 0,  0);
      step("lu_rs",         1,  8, 0, 0, 1, 8, 0, 0, 0,  LDU, 0,  0);
      step("lu_after",      1,  8, 0, 0, 0, 8, 0, 0, 0,  DEF, 0,  1);
      step("reg_zero",      1,  0, 0, 0, 1, 0, 0, 0, 0,  DEF, 0,  1);
      step("rt_unused",     1,  0, 9, 0, 1, 9, 0, 0, 0,  DEF, 0,  1);
      step("rt_used",       1,  0, 9, 1, 1, 9, 0, 0, 0,  LDU, 0,  1);
      step("br_over_lu",    1,  0, 9, 1, 1, 9, 0, 1, 0,  BRN, 0,  2);
      step("br_after",      1,  0, 0, 0, 0, 0, 0, 0, 0,  DEF, 0,  2);
      step("clr",           1,  0, 0, 0, 0, 0, 0, 0, 1,  DEF, 0,  2);
      step("clr_after",     1,  0, 0, 0, 0, 0, 0, 0, 0,  DEF, 0,  0);
      step("md_c1",         1,  0, 0, 0, 0, 0, 1, 0, 0,  FRZ, 0,  0);
      step("md_c2_br",      1,  3, 0, 0, 1, 3, 1, 1, 0,  FRZ, 1,  1);
      step("md_c3",         1,  0, 0, 0, 0, 0, 1, 0, 0,  FRZ, 1,  2);
      step("md_c4_release", 1,  3, 0, 0, 1, 3, 1, 1, 0,  DEF, 1,  3);
      step("md_c5_run",     1,  0, 0, 0, 0, 0, 0, 0, 0,  DEF, 0,  3);
      step("rmw_c1",        1,  0, 0, 0, 0, 0, 1, 0, 0,  FRZ, 0,  3);
      step("rmw_c2",        1,  0, 0, 0, 0, 0, 1, 0, 0,  FRZ, 1,  4);
      step("rmw_rst",       0,  0, 0, 0, 0, 0, 1, 0, 0,  RST, 0,  0);
      step("rmw_rst2",      0,  0, 0, 0, 0, 0, 1, 0, 0,  RST, 0,  0);
      step("rmw_run",       1,  0, 0, 0, 0, 0, 0, 0, 0,  DEF, 0,  0);
      for (int unsigned i = 0; i < 20; i++)
         step("sat_hold",   1,  5, 0, 0, 1, 5, 0, 0, 0,  LDU, 0,  (i < 15) ? 4'(i) : 4'd15);
      step("sat_clr",       1,  5, 0, 0, 1, 5, 0, 0, 1,  LDU, 0,  15);
      step("sat_cleared",   1,  5, 0, 0, 1, 5, 0, 0, 0,  LDU, 0,  0);
      step("sat_restart",   1,  0, 0, 0, 0, 0, 0, 0, 0,  DEF, 0,  1);

      for (int unsigned w = 0; w < 10 && sb.size() > 0; w++)
         @(negedge Clk);
      #5;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller that consumes the EX-stage fields delivered by the ID/EX register and drives the write-enable, flush and bubble controls back into the PC, IF/ID, ID/EX and EX/MEM stages. It resolves three hazard types:
- load-use stalls;
- taken-branch flushes;
- multi-cycle mult/div occupancy of EX, through a small FSM and cycle counter.

It also keeps a saturating stall-cycle performance counter.

## Interface
- MULDIV_CYCLES, 4, total cycles a mult/div instruction occupies EX; legal range 2..15.
- STALL_CNT_W, 16, width of stall performance counter.

- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  rs field of instruction in ID.
- ID_Rt  in  5  rt field of instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_MemRead  in  1  EX instruction is a load.
- EX_DestReg  in  5  resolved destination register of EX instruction.
- EX_IsMulDiv  in  1  EX instruction is mult/div.
- EX_BranchTaken  in  1  branch/jump in EX resolved taken.
- Stall_Clr  in  1  synchronous clear of Stall_Cycles.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID contents replaced by NOP.
- IDEX_Write  out  1  ID/EX load enable; 0 holds current contents.
- IDEX_Flush  out  1  ID/EX loads zeroed control fields (bubble).
- EXMEM_Bubble  out  1  EX/MEM loads zeroed control fields.
- MulDiv_Busy  out  1  high while the FSM is in WAIT.
- Stall_Cycles  out  STALL_CNT_W  count of cycles with PC_Write=0.

## Operation
- State register: RUN, WAIT. Counter cnt, 4 bits.
- Default (RUN, no hazard) outputs:
  - PC_Write=IFID_Write=IDEX_Write=1.
  - IFID_Flush=IDEX_Flush=EXMEM_Bubble=0.
- The three hazard conditions below are evaluated in RUN, in priority order, with the higher one winning.
- Freeze (highest): EX_IsMulDiv=1.
  - Outputs: PC_Write=IFID_Write=IDEX_Write=0, EXMEM_Bubble=1.
  - cnt<=MULDIV_CYCLES-1, state<=WAIT.
- Branch: EX_BranchTaken=1.
  - Outputs: IFID_Flush=1, IDEX_Flush=1, PC_Write=1. The load-use check is ignored because the ID instruction is wrong-path.
- Load-use: EX_MemRead=1, EX_DestReg!=0, and either EX_DestReg==ID_Rs or (ID_UsesRt and EX_DestReg==ID_Rt).
  - Outputs: PC_Write=0, IFID_Write=0, IDEX_Write=1, IDEX_Flush=1.
- WAIT state:
  - If cnt!=1: freeze outputs as above, cnt<=cnt-1.
  - If cnt==1 (release cycle): default outputs, state<=RUN, cnt<=0. EX_BranchTaken and the load-use check are ignored in WAIT, because EX holds the mult/div.
- A mult/div therefore occupies EX for exactly MULDIV_CYCLES cycles.
- MulDiv_Busy = (state==WAIT).
- Stall_Cycles:
  - Increments on each clock edge where PC_Write=0.
  - Saturates at all-ones.
  - Stall_Clr=1 forces 0 and takes priority over the increment.

## Timing
- All hazard outputs are combinational from state and current inputs, with zero-cycle latency, so stage registers act on the same edge.
- State, cnt and Stall_Cycles update on the rising edge of Clk.
- A load-use stall lasts exactly one cycle; on the next cycle EX holds the bubble, so the condition clears naturally.
- While Rst_n=0:
  - state=RUN, cnt=0, Stall_Cycles=0.
  - Outputs forced to PC_Write=IFID_Write=IDEX_Write=0, IFID_Flush=IDEX_Flush=EXMEM_Bubble=1, MulDiv_Busy=0.
- Reset asserted mid-WAIT aborts the sequence. The first cycle after deassertion is RUN with default rules.
- Stall_Cycles does not count reset cycles.

## Structure
- A shared pipeline package holds:
  - the state enum (RUN=1'b0, WAIT=1'b1);
  - the MULDIV_CYCLES default;
  - the register-zero constant (5'd0).
- One natural sub-module: sat_counter, a parameterized-width saturating counter with sync clear, used for Stall_Cycles.
- The rest of the block is a single module.

## Test plan
- Load-use: EX_MemRead=1, EX_DestReg=8, ID_Rs=8 in RUN.
  - Same cycle: PC_Write=0, IFID_Write=0, IDEX_Flush=1.
  - Next cycle, with EX_MemRead=0: defaults restored, Stall_Cycles=1.
- Register zero and rt gating:
  - EX_MemRead=1, EX_DestReg=0, ID_Rs=0 -> no stall.
  - EX_DestReg=9, ID_Rt=9, ID_UsesRt=0 -> no stall.
  - Same as above with ID_UsesRt=1 -> stall.
- Branch over load-use: EX_BranchTaken=1 together with a load-use match.
  - Required: IFID_Flush=1, IDEX_Flush=1, PC_Write=1, and Stall_Cycles unchanged.
- Mult/div with MULDIV_CYCLES=4: EX_IsMulDiv held high.
  - Freeze for 3 cycles, MulDiv_Busy high for cycles 2–4.
  - Release on the 4th cycle, RUN on the 5th, Stall_Cycles=3.
- Reset mid-WAIT: assert Rst_n=0 at cnt=2.
  - Immediate forced reset outputs.
  - After deassertion: RUN, MulDiv_Busy=0, Stall_Cycles=0.
- Saturation and clear with STALL_CNT_W=4: hold a stall for 20 cycles.
  - Stall_Cycles stops at 15.
  - Stall_Clr pulse during a stall gives 0 on the next edge.
